// File: rtl/fetch_rx_buffer.sv
// fetch_rx_buffer: fetch-to-decode pipeline buffer.
// Circular FIFO of {PC, PC+4, instruction} entries with valid/ready on both sides.
// A redirect flush empties the buffer and tallies the discarded entries. When the
// buffer is empty, decode sees a NOP bubble.
module fetch_rx_buffer #(
  parameter int unsigned          DWIDTH    = 32,
  parameter int unsigned          DEPTH     = 2,
  parameter logic [DWIDTH-1:0]    NOP_INSTR = 32'h00000013,
  parameter int unsigned          CNT_W     = 8,
  localparam int unsigned         PTR_W     = $clog2(DEPTH),
  localparam int unsigned         OCC_W     = $clog2(DEPTH) + 1
) (
  input  logic              Clk_Core,
  input  logic              Rst_Core,
  input  logic              Fetch_Valid,
  output logic              Fetch_Ready,
  input  logic [DWIDTH-1:0] Fetch_PC,
  input  logic [DWIDTH-1:0] Fetch_PC_Plus,
  input  logic [DWIDTH-1:0] Fetch_Instruction,
  input  logic              Flush,
  output logic              Dec_Valid,
  input  logic              Dec_Ready,
  output logic [DWIDTH-1:0] Dec_PC,
  output logic [DWIDTH-1:0] Dec_PC_Plus,
  output logic [DWIDTH-1:0] Dec_Instruction,
  output logic [OCC_W-1:0]  Occupancy,
  output logic [CNT_W-1:0]  Drop_Count
);

  // The saturating add needs room for the sum of the counter and the occupancy.
  localparam int unsigned SUM_W = ((CNT_W > OCC_W) ? CNT_W : OCC_W) + 1;
  localparam logic [SUM_W-1:0] DROP_MAX = SUM_W'({CNT_W{1'b1}});

  logic [3*DWIDTH-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [OCC_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] drop_q, drop_d;

  logic             push;
  logic             pop;
  logic [SUM_W-1:0] drop_sum;
  logic [3*DWIDTH-1:0] head;

  // Handshake qualifiers; ready depends only on occupancy so there is no
  // combinational path from decode back to fetch.
  always_comb begin
    Fetch_Ready = !Rst_Core && (count_q < OCC_W'(DEPTH));
    Dec_Valid   = !Rst_Core && (count_q != '0);
    push        = Fetch_Valid && Fetch_Ready && !Flush;
    pop         = Dec_Valid && Dec_Ready && !Flush;
  end

  // Next-state for pointers, occupancy and the drop counter.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    drop_d   = drop_q;
    drop_sum = SUM_W'(drop_q) + SUM_W'(count_q);
    if (Flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      drop_d   = (drop_sum > DROP_MAX) ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end
  end

  // Control state register; reset takes priority over flush.
  always_ff @(posedge Clk_Core) begin
    if (Rst_Core) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      drop_q   <= drop_d;
    end
  end

  // Entry storage; contents are don't-care until written, so no reset.
  always_ff @(posedge Clk_Core) begin
    if (push && !Rst_Core) begin
      mem_q[wr_ptr_q] <= {Fetch_PC, Fetch_PC_Plus, Fetch_Instruction};
    end
  end

  // Decode-side view of the head entry, or a NOP bubble when nothing is valid.
  always_comb begin
    head            = mem_q[rd_ptr_q];
    Dec_PC          = '0;
    Dec_PC_Plus     = '0;
    Dec_Instruction = NOP_INSTR;
    if (Dec_Valid) begin
      Dec_PC          = head[3*DWIDTH-1:2*DWIDTH];
      Dec_PC_Plus     = head[2*DWIDTH-1:DWIDTH];
      Dec_Instruction = head[DWIDTH-1:0];
    end
    Occupancy  = count_q;
    Drop_Count = drop_q;
  end

endmodule

// File: tb/tb_fetch_rx_buffer.sv
// Directed bench for fetch_rx_buffer: fill, full+pop, flush, streaming with
// pointer wrap, mid-operation reset, and drop-counter saturation (CNT_W=2 copy).
module tb_fetch_rx_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        f_valid;
  logic [31:0] f_pc, f_pcp, f_instr;
  logic        flush;
  logic        d_ready;

  logic        f_ready, d_valid;
  logic [31:0] d_pc, d_pcp, d_instr;
  logic [1:0]  occ;
  logic [7:0]  drop;

  logic        s_f_ready, s_d_valid;
  logic [31:0] s_d_pc, s_d_pcp, s_d_instr;
  logic [1:0]  s_occ;
  logic [1:0]  s_drop;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_rx_buffer dut (
    .Clk_Core(clk), .Rst_Core(rst),
    .Fetch_Valid(f_valid), .Fetch_Ready(f_ready),
    .Fetch_PC(f_pc), .Fetch_PC_Plus(f_pcp), .Fetch_Instruction(f_instr),
    .Flush(flush),
    .Dec_Valid(d_valid), .Dec_Ready(d_ready),
    .Dec_PC(d_pc), .Dec_PC_Plus(d_pcp), .Dec_Instruction(d_instr),
    .Occupancy(occ), .Drop_Count(drop)
  );

  fetch_rx_buffer #(.CNT_W(2)) dut_s (
    .Clk_Core(clk), .Rst_Core(rst),
    .Fetch_Valid(f_valid), .Fetch_Ready(s_f_ready),
    .Fetch_PC(f_pc), .Fetch_PC_Plus(f_pcp), .Fetch_Instruction(f_instr),
    .Flush(flush),
    .Dec_Valid(s_d_valid), .Dec_Ready(d_ready),
    .Dec_PC(s_d_pc), .Dec_PC_Plus(s_d_pcp), .Dec_Instruction(s_d_instr),
    .Occupancy(s_occ), .Drop_Count(s_drop)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] pc);
    f_valid = 1'b1;
    f_pc    = pc;
    f_pcp   = pc + 32'd4;
    f_instr = 32'hA000_0000 | pc;
  endtask

  initial begin
    rst = 1'b1; f_valid = 1'b0; f_pc = '0; f_pcp = '0; f_instr = '0;
    flush = 1'b0; d_ready = 1'b0;
    step();
    chk("rst_fready", {31'b0, f_ready}, 32'd0);
    chk("rst_dvalid", {31'b0, d_valid}, 32'd0);
    rst = 1'b0;
    step();
    chk("init_occ", {30'b0, occ}, 32'd0);
    chk("init_pc", d_pc, 32'd0);
    chk("init_pcp", d_pcp, 32'd0);
    chk("init_instr", d_instr, 32'h13);
    chk("init_fready", {31'b0, f_ready}, 32'd1);
    chk("init_drop", {24'b0, drop}, 32'd0);

    // Fill with decode stalled
    offer(32'h0);
    step();
    chk("fill1_occ", {30'b0, occ}, 32'd1);
    chk("fill1_dvalid", {31'b0, d_valid}, 32'd1);
    chk("fill1_instr", d_instr, 32'hA000_0000);
    offer(32'h4);
    step();
    chk("fill2_occ", {30'b0, occ}, 32'd2);
    chk("fill2_fready", {31'b0, f_ready}, 32'd0);
    chk("fill2_pc", d_pc, 32'h0);
    chk("fill2_pcp", d_pcp, 32'h4);

    // Full + pop: the offered entry is not admitted that edge
    offer(32'h8);
    d_ready = 1'b1;
    step();
    chk("fullpop_occ", {30'b0, occ}, 32'd1);
    chk("fullpop_fready", {31'b0, f_ready}, 32'd1);
    chk("fullpop_pc", d_pc, 32'h4);
    d_ready = 1'b0;
    step();
    chk("refill_occ", {30'b0, occ}, 32'd2);

    // Flush with an offer and a pop request both present
    flush = 1'b1; d_ready = 1'b1; offer(32'hC);
    step();
    flush = 1'b0; f_valid = 1'b0; d_ready = 1'b0;
    chk("flush_occ", {30'b0, occ}, 32'd0);
    chk("flush_dvalid", {31'b0, d_valid}, 32'd0);
    chk("flush_instr", d_instr, 32'h13);
    chk("flush_pc", d_pc, 32'd0);
    chk("flush_drop", {24'b0, drop}, 32'd2);
    chk("flush_drop_s", {30'b0, s_drop}, 32'd2);

    // Streaming with simultaneous push and pop; 17 entries wrap the pointers
    d_ready = 1'b1;
    for (int i = 0; i <= 16; i++) begin
      offer(32'(i * 4));
      step();
      chk("stream_pc", d_pc, 32'(i * 4));
      chk("stream_instr", d_instr, 32'hA000_0000 | 32'(i * 4));
      chk("stream_occ", {30'b0, occ}, 32'd1);
    end
    f_valid = 1'b0;
    step();
    chk("drain_occ", {30'b0, occ}, 32'd0);
    chk("drain_dvalid", {31'b0, d_valid}, 32'd0);
    d_ready = 1'b0;

    // Reset in the middle of operation
    offer(32'h100);
    step();
    f_valid = 1'b0;
    chk("prerst_occ", {30'b0, occ}, 32'd1);
    rst = 1'b1;
    #1;
    chk("inrst_fready", {31'b0, f_ready}, 32'd0);
    chk("inrst_dvalid", {31'b0, d_valid}, 32'd0);
    step();
    chk("inrst2_fready", {31'b0, f_ready}, 32'd0);
    chk("inrst2_dvalid", {31'b0, d_valid}, 32'd0);
    rst = 1'b0;
    step();
    chk("postrst_occ", {30'b0, occ}, 32'd0);
    chk("postrst_drop", {24'b0, drop}, 32'd0);
    chk("postrst_drop_s", {30'b0, s_drop}, 32'd0);
    chk("postrst_fready", {31'b0, f_ready}, 32'd1);

    // Three flushes of two entries each: full-width adds, narrow one saturates
    for (int k = 1; k <= 3; k++) begin
      offer(32'h200);
      step();
      offer(32'h204);
      step();
      f_valid = 1'b0;
      chk("sat_occ", {30'b0, occ}, 32'd2);
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("sat_drop", {24'b0, drop}, 32'(2 * k));
      chk("sat_drop_s", {30'b0, s_drop}, (k == 1) ? 32'd2 : 32'd3);
    end
    step();
    chk("sat_hold_s", {30'b0, s_drop}, 32'd3);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("empty_flush_drop", {24'b0, drop}, 32'd6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
